// File: rtl/uart_pkg.sv
// Shared UART RX definitions: receive FSM state encoding and the legal oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART RX sequencer: start detect, counter enable, per-bit strobe decode and frame result pulses.
// Parity support (PARITY state, par_chk_en, par_err_o) is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic [5:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err,
    output logic       par_err_o,
    output logic       busy
);

    localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH);

    uart_rx_state_t state_q, state_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           perr_pending;
    logic [5:0]     half;
    logic [5:0]     edge_last;
    logic           at_end;
    logic           at_strobe;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_err_q, par_err_d;
    logic par_err_o_q, par_err_o_d;
    logic par_chk_d;
`else
    logic unused_par;
    assign unused_par = ^{par_en, par_err};
`endif

    assign half      = prescale >> 1;
    assign edge_last = prescale - 6'd1;
    assign at_end    = (edge_cnt == edge_last);
    assign at_strobe = (edge_cnt == half + 6'd2);

    assign busy        = (state_q != IDLE);
    assign cnt_enable  = busy;
    // Three samples centred on the bit middle feed the sampler's majority vote.
    assign dat_samp_en = busy && (edge_cnt >= half - 6'd1) && (edge_cnt <= half + 6'd1);

    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

`ifdef UART_RX_PARITY_EN
    assign perr_pending = par_err_q;
    assign par_err_o    = par_err_o_q;
    assign par_chk_en   = par_chk_d;
`else
    assign perr_pending = 1'b0;
    assign par_err_o    = 1'b0;
    assign par_chk_en   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        strt_chk_en  = 1'b0;
        deser_en     = 1'b0;
        stp_chk_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d     = par_en_q;
        par_err_d    = par_err_q;
        par_err_o_d  = 1'b0;
        par_chk_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = par_en;
                    par_err_d = 1'b0;
`endif
                end
            end
            START: begin
                strt_chk_en = at_strobe;
                if (at_end) begin
                    state_d = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                deser_en = at_strobe;
                if (at_end && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_chk_d = at_strobe;
                if (at_end) begin
                    par_err_d = par_err;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                stp_chk_en = at_strobe;
                if (at_end) begin
                    state_d      = IDLE;
                    frame_err_d  = stp_err;
                    data_valid_d = !stp_err && !perr_pending;
`ifdef UART_RX_PARITY_EN
                    par_err_o_d  = par_err_q && !stp_err;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q    <= 1'b0;
            par_err_q   <= 1'b0;
            par_err_o_q <= 1'b0;
        end else begin
            par_en_q    <= par_en_d;
            par_err_q   <= par_err_d;
            par_err_o_q <= par_err_o_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame-level reference model checked every cycle against all outputs.
module tb_uart_rx_fsm;
    import uart_pkg::*;

    localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic [5:0] prescale = PRESCALE_8;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_err, par_err_o, busy;
    logic [9:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_no = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the shared edge/bit counter instanced at the uart_rx top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .prescale   (prescale),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .cnt_enable (cnt_enable),
        .dat_samp_en(dat_samp_en),
        .deser_en   (deser_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .par_err_o  (par_err_o),
        .busy       (busy)
    );

    assign obs = {busy, cnt_enable, dat_samp_en, deser_en, strt_chk_en,
                  par_chk_en, stp_chk_en, data_valid, frame_err, par_err_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom & 32'd1);
    endfunction

    // Expected output vector for cycle o counted from the first START cycle, from the frame rules:
    // nb bit periods of ps cycles, majority window around ps/2, one strobe at ps/2+2, result pulse after.
    function automatic logic [9:0] exp_vec(input int o, input int ps, input bit p,
                                           input bit glitch, input bit perr, input bit serr);
        int nb;
        int k;
        int e;
        int h;
        logic [9:0] v;
        nb = glitch ? 1 : DW + 2 + (p ? 1 : 0);
        k  = o / ps;
        e  = o % ps;
        h  = ps / 2;
        v  = '0;
        if (o < nb * ps) begin
            v[9] = 1'b1;
            v[8] = 1'b1;
            v[7] = (e >= h - 1) && (e <= h + 1);
            if (e == h + 2) begin
                v[5] = (k == 0);
                v[6] = (k >= 1) && (k <= DW);
                v[4] = p && (k == DW + 1);
                v[3] = !glitch && (k == nb - 1);
            end
        end else if (o == nb * ps && !glitch) begin
            v[2] = !serr && !(p && perr);
            v[1] = serr;
            v[0] = p && perr && !serr;
        end
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("idle", 32'(obs), 32'd0);
            rx_in       = 1'b1;
            par_en      = rbit();
            strt_glitch = rbit();
            par_err     = rbit();
            stp_err     = rbit();
            @(negedge clk);
        end
    endtask

    // Checker inputs carry their real result only from ps/2+3 to the bit end; noise elsewhere.
    task automatic run_frame(input int ps, input bit pe, input bit glitch, input bit perr,
                             input bit serr, input logic [7:0] data, input bit chain,
                             input bit next_pe, input int abort_at);
        bit p;
        int nb;
        int total;
        int k;
        int e;
        int h;
        bit win;
        p     = PAR_BUILT && pe;
        nb    = glitch ? 1 : DW + 2 + (p ? 1 : 0);
        total = nb * ps;
        h     = ps / 2;
        frame_no++;
        if (!started) begin
            prescale = 6'(ps);
            check_eq("pre_idle", 32'(obs), 32'd0);
            rx_in  = 1'b0;
            par_en = pe;
            @(negedge clk);
        end
        started = 1'b0;
        for (int o = 0; o <= total; o++) begin
            if (o == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_async", 32'(obs), 32'd0);
                @(negedge clk);
                check_eq("rst_hold", 32'(obs), 32'd0);
                rst_n = 1'b1;
                rx_in = 1'b1;
                return;
            end
            check_eq($sformatf("f%0d_o%0d", frame_no, o), 32'(obs),
                     32'(exp_vec(o, ps, p, glitch, perr, serr)));
            k   = o / ps;
            e   = o % ps;
            win = (e >= h + 3);
            if (o == total) begin
                rx_in       = chain ? 1'b0 : 1'b1;
                par_en      = chain ? next_pe : rbit();
                strt_glitch = rbit();
                par_err     = rbit();
                stp_err     = rbit();
                started     = chain;
            end else begin
                if (glitch)
                    rx_in = (o < 3) ? 1'b0 : 1'b1;
                else if (k == 0)
                    rx_in = 1'b0;
                else if (k <= DW)
                    rx_in = data[k-1];
                else if (p && k == DW + 1)
                    rx_in = ^data;
                else
                    rx_in = 1'b1;
                par_en      = rbit();
                strt_glitch = (k == 0 && win) ? glitch : rbit();
                par_err     = (p && k == DW + 1 && win) ? perr : rbit();
                stp_err     = (!glitch && k == nb - 1 && win) ? serr : rbit();
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int  ps;
        bit  pe;
        bit  nxt_pe;
        bit  chain;
        bit  glitch;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset", 32'(obs), 32'd0);
        end
        rst_n = 1'b1;
        idle(3);

        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, -1);
        run_frame(32, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 4 * 16 + 8);
        idle(3);
        run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, -1);
        idle(2);
        run_frame(8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, -1);
        idle(1);

        ps     = 8;
        nxt_pe = rbit();
        for (int i = 0; i < 24; i++) begin
            if (!started) begin
                case ($urandom % 3)
                    0:       ps = int'(PRESCALE_8);
                    1:       ps = int'(PRESCALE_16);
                    default: ps = int'(PRESCALE_32);
                endcase
            end
            pe     = nxt_pe;
            nxt_pe = rbit();
            glitch = (($urandom % 8) == 0);
            chain  = (($urandom % 3) == 0);
            run_frame(ps, pe, glitch, rbit(), rbit(), 8'($urandom), chain, nxt_pe, -1);
            if (!started)
                idle(int'($urandom % 4));
        end
        if (started)
            run_frame(ps, nxt_pe, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, -1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-path sequencer for the UART RX. Detects the start-bit falling edge and enables the shared edge/bit counter. Decodes the counter's `edge_cnt`/`bit_cnt` into one-cycle enables for the data sampler, deserializer and start/parity/stop checkers. Gates the final `data_valid` on checker results, sitting between the synchronized `rx_in` line and the RX datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame; `bit_cnt` must be able to hold `DATA_WIDTH+2`.

Ports:
- `clk` input 1: oversampling clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_in` input 1: synchronized serial line; idle high.
- `par_en` input 1: frame carries a parity bit.
- `prescale` input 6: oversampling ratio; legal values are 8, 16 and 32.
- `edge_cnt` input 6: edge count from the counter.
- `bit_cnt` input 4: bit count from the counter.
- `strt_glitch` input 1: start-check result.
- `par_err` input 1: parity-check result.
- `stp_err` input 1: stop-check result.
- `cnt_enable` output 1: run the counter; low clears it.
- `dat_samp_en` output 1: sampler window.
- `deser_en` output 1: shift the sampled bit into the deserializer.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en` output 1 each: checker strobes.
- `data_valid` output 1: frame accepted; one-cycle pulse.
- `frame_err` output 1: stop error; one-cycle pulse.
- `par_err_o` output 1: parity error; one-cycle pulse.
- `busy` output 1: FSM not in IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Define `HALF = prescale>>1` and `END = (edge_cnt == prescale-1)`.
- IDLE:
  - `cnt_enable=0`.
  - `rx_in==0` → START on the next clock.
  - A line held low (break) re-enters START every time.
- START, at END:
  - `strt_glitch==1` → IDLE.
  - Otherwise → DATA.
- DATA, at END with `bit_cnt==DATA_WIDTH`:
  - → PARITY if `par_en`.
  - → STOP otherwise.
- PARITY, at END:
  - Latch `par_err` into `par_err_q`.
  - → STOP.
- STOP, at END:
  - → IDLE.
  - Next cycle pulse exactly one of: `data_valid`, `frame_err` (if `stp_err`), or `par_err_o` (if `par_err_q` and not `stp_err`).
  - `par_err_q` clears on START entry.
- `cnt_enable = busy`. When the FSM returns to IDLE, the counter clears one cycle later.
- `dat_samp_en` = `busy` and `edge_cnt` ∈ {HALF-1, HALF, HALF+1} (3-sample majority window).
- At `edge_cnt == HALF+2`, exactly one strobe is asserted, chosen by state:
  - START → `strt_chk_en`.
  - DATA → `deser_en`.
  - PARITY → `par_chk_en`.
  - STOP → `stp_chk_en`.
- Checker result inputs are sampled only at END. Checkers hold their result from HALF+3 through END.
- `par_en` is sampled at START entry and held for the frame; changes mid-frame are ignored.

## Timing
- Reset: state IDLE, `par_err_q=0`, all outputs 0.
- Strobes and `dat_samp_en` are combinational decodes of state and `edge_cnt`, so they are valid in the same cycle as the counter value.
- `data_valid`, `frame_err` and `par_err_o` are registered: asserted one cycle after STOP END, for one cycle.
- Start-edge latency: `rx_in` falling → START after 1 clock. `edge_cnt=0` in the first START cycle.
- Frame length: `(DATA_WIDTH+2+par_en)*prescale + 1` cycles from IDLE exit back to IDLE.
- Back-to-back frames: a start bit immediately after stop is accepted with 1-cycle phase slip.
- Reset asserted mid-frame: immediate IDLE, no pulses, counter cleared via `cnt_enable=0`.
- Illegal `prescale`: behaviour undefined. Verification constrains `prescale` to 8, 16 or 32.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, `par_chk_en`, `par_err_q` and `par_err_o` are present as described.
- `UART_RX_PARITY_EN` undefined:
  - PARITY state and `par_err_q` are not built.
  - `par_en` and `par_err` are ignored.
  - `par_chk_en` and `par_err_o` are tied 0.
  - DATA always goes to STOP.

## Structure
- Shared package `uart_pkg`: state enum `uart_rx_state_t` (IDLE..STOP) and the legal prescale constants `PRESCALE_8/16/32`.
- No sub-module; the FSM and strobe decode stay in this one file.
- The counter remains a separate instance, wired at the `uart_rx` top.

## Test plan
- Prescale 8, no parity, frame 0xA5 with valid stop → `deser_en` pulses 8 times at `edge_cnt=6`; `data_valid` pulses once, 81 cycles after the falling edge.
- Prescale 16, even parity, 0x3C, `par_err=1` at PARITY END → `par_err_o` single pulse; no `data_valid`.
- 3-cycle low glitch: checker sets `strt_glitch=1` at START END → FSM returns to IDLE; no `deser_en` pulses, no output pulses.
- Prescale 32, `stp_err=1` at STOP END → `frame_err` pulse; then an immediate second good frame 0xFF → `data_valid` pulse.
- `rst_n` low during DATA bit 4 → all outputs 0 in the same cycle and `busy=0`; a subsequent frame 0x01 is received correctly.
- Compiled without `UART_RX_PARITY_EN`, `par_en=1` → no PARITY state; `par_chk_en` never asserts; frame length is 10*prescale+1.
